// File: rtl/intersection_pkg.sv
// Shared encodings and default timing for the intersection controller.
package intersection_pkg;

  // Phase encoding; WALK is the exclusive pedestrian phase with all lamps red.
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    NS_ALLRED = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    EW_ALLRED = 3'd5,
    WALK      = 3'd6
  } state_t;

  // One-hot lamp encoding, MSB = red.
  typedef logic [2:0] lamp_t;
  localparam lamp_t RED    = 3'b100;
  localparam lamp_t YELLOW = 3'b010;
  localparam lamp_t GREEN  = 3'b001;

  localparam int DEF_T_GREEN_MIN = 8;
  localparam int DEF_T_GREEN_MAX = 20;
  localparam int DEF_T_YELLOW    = 3;
  localparam int DEF_T_ALLRED    = 2;
  localparam int DEF_T_WALK      = 6;
  localparam int DEF_CNT_W       = 8;

  typedef struct packed {
    lamp_t ns;
    lamp_t ew;
    logic  walk;
  } lamps_t;

  // Lamp pattern for a phase; only one approach can ever be non-red.
  function automatic lamps_t decode_lamps(input state_t s);
    lamps_t l;
    l = '{ns: RED, ew: RED, walk: 1'b0};
    case (s)
      NS_GREEN:  l.ns   = GREEN;
      NS_YELLOW: l.ns   = YELLOW;
      EW_GREEN:  l.ew   = GREEN;
      EW_YELLOW: l.ew   = YELLOW;
      WALK:      l.walk = 1'b1;
      default:   l      = '{ns: RED, ew: RED, walk: 1'b0};
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: clears on phase entry, counts up, holds at limit.
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] count,
  output logic             tc
);

  // Count toward limit; clear (phase entry) restarts from zero.
  always_ff @(posedge clk) begin
    if (!reset || clear)
      count <= '0;
    else if (enable && (count < limit))
      count <= count + CNT_W'(1);
  end

  // >= so a limit that drops below the running count still reads as expired.
  assign tc = (count >= limit);

endmodule

// File: rtl/intersection_controller.sv
// Two-approach traffic controller with exclusive pedestrian walk phase.
module intersection_controller
  import intersection_pkg::*;
#(
  parameter int T_GREEN_MIN = DEF_T_GREEN_MIN,
  parameter int T_GREEN_MAX = DEF_T_GREEN_MAX,
  parameter int T_YELLOW    = DEF_T_YELLOW,
  parameter int T_ALLRED    = DEF_T_ALLRED,
  parameter int T_WALK      = DEF_T_WALK,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       car_ns,
  input  logic       car_ew,
  input  logic       ped_req,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       walk
);

  localparam logic [CNT_W-1:0] LIM_GMIN = CNT_W'(T_GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] LIM_GMAX = CNT_W'(T_GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] LIM_Y    = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LIM_AR   = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] LIM_W    = CNT_W'(T_WALK - 1);

  state_t           state, nxt;
  logic [CNT_W-1:0] count, limit;
  logic             tc, advance;
  logic             ped_pending;
  logic             walk_to_ew;   // WALK exits to EW when NS was the last green

  // Terminal count for the current phase; greens saturate at max-green.
  always_comb begin
    limit = LIM_GMAX;
    case (state)
      NS_GREEN, EW_GREEN:   limit = LIM_GMAX;
      NS_YELLOW, EW_YELLOW: limit = LIM_Y;
      NS_ALLRED, EW_ALLRED: limit = LIM_AR;
      WALK:                 limit = LIM_W;
      default:              limit = LIM_GMAX;
    endcase
  end

  // Phase transitions. A green yields once min-green has elapsed and there is
  // demand, either because its own approach emptied or max-green was hit.
  always_comb begin
    nxt = state;
    case (state)
      NS_GREEN:
        if ((count >= LIM_GMIN) && (car_ew || ped_pending) && (!car_ns || tc))
          nxt = NS_YELLOW;
      NS_YELLOW: if (tc) nxt = NS_ALLRED;
      NS_ALLRED: if (tc) nxt = ped_pending ? WALK : EW_GREEN;
      EW_GREEN:
        if ((count >= LIM_GMIN) && (car_ns || ped_pending) && (!car_ew || tc))
          nxt = EW_YELLOW;
      EW_YELLOW: if (tc) nxt = EW_ALLRED;
      EW_ALLRED: if (tc) nxt = ped_pending ? WALK : NS_GREEN;
      WALK:      if (tc) nxt = walk_to_ew ? EW_GREEN : NS_GREEN;
      default:   nxt = NS_GREEN;
    endcase
  end

  assign advance = (nxt != state);

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (advance),
    .enable (1'b1),
    .limit  (limit),
    .count  (count),
    .tc     (tc)
  );

  // State register with lamps decoded from the next state so outputs are
  // registered yet always match the current phase.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= NS_GREEN;
      ns_light <= GREEN;
      ew_light <= RED;
      walk     <= 1'b0;
    end else begin
      state                      <= nxt;
      {ns_light, ew_light, walk} <= decode_lamps(nxt);
    end
  end

  // Pedestrian latch: cleared when WALK begins, presses during WALK ignored.
  always_ff @(posedge clk) begin
    if (!reset)
      ped_pending <= 1'b0;
    else if (nxt == WALK && state != WALK)
      ped_pending <= 1'b0;
    else if (ped_req && state != WALK)
      ped_pending <= 1'b1;
  end

  // Remember which approach handed over to WALK so the other one goes next.
  always_ff @(posedge clk) begin
    if (!reset)
      walk_to_ew <= 1'b0;
    else if (state == NS_ALLRED)
      walk_to_ew <= 1'b1;
    else if (state == EW_ALLRED)
      walk_to_ew <= 1'b0;
  end

endmodule
